// File: rtl/pi_vel_pkg.sv
// Shared FSM encoding, product width derivation and wide saturating arithmetic
// for the PI velocity controller.
package pi_vel_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ERR  = 3'd1;
    localparam logic [2:0] ST_INT  = 3'd2;
    localparam logic [2:0] ST_MUL  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    // Working width for clamp/saturate; comfortably wider than any datapath value.
    localparam int unsigned WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int unsigned prod_w(input int unsigned acc_w, input int unsigned gain_w);
        return acc_w + gain_w + 1;
    endfunction

    function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
        wide_t hi;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        return clamp(a + b, -hi - wide_t'(1), hi);
    endfunction

endpackage

// File: rtl/vel_estimator.sv
// Tick-qualified encoder sampler: emits the position delta over each window of
// VEL_WIN ticks, modulo 2^DATA_W so encoder wrap is absorbed.
module vel_estimator
    import pi_vel_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned VEL_WIN = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [DATA_W-1:0] pos,
    output logic [DATA_W-1:0] vel
);

    localparam int unsigned WIN_W = (VEL_WIN > 1) ? $clog2(VEL_WIN) : 1;

    logic [WIN_W-1:0]  win_cnt;
    logic [DATA_W-1:0] win_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt   <= '0;
            win_start <= '0;
            vel       <= '0;
        end else if (tick) begin
            if (win_cnt == WIN_W'(VEL_WIN - 1)) begin
                vel       <= pos - win_start;
                win_start <= pos;
                win_cnt   <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pi_vel_ctrl_param.sv
// PI velocity controller with conditional anti-windup and full-width clamp.
// Define PI_VEL_FF_EN to add the kff feedforward input.
module pi_vel_ctrl_param
    import pi_vel_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned GAIN_W    = 16,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned CLK_DIV   = 5000,
    parameter int unsigned VEL_WIN   = 10,
    parameter int unsigned OUT_SHIFT = 32,
    parameter int          OUT_LIMIT = 4000,
    parameter int          AW_LIMIT  = 3900,
    parameter int          DEADBAND  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear_int,
    input  logic [DATA_W-1:0] desired_vel,
    input  logic [DATA_W-1:0] actual_pos,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] ki,
`ifdef PI_VEL_FF_EN
    input  logic [GAIN_W-1:0] kff,
`endif
    output logic [DATA_W-1:0] actual_vel,
    output logic [OUT_W-1:0]  control_signal,
    output logic              ctrl_valid,
    output logic              saturated
);

    localparam int unsigned PROD_W = prod_w(ACC_W, GAIN_W);
    localparam int unsigned SUM_W  = PROD_W + 2;
    localparam int unsigned CNT_W  = $clog2(CLK_DIV);

    logic [CNT_W-1:0]         div_cnt;
    logic                     tick;
    logic [2:0]               state;
    logic [DATA_W-1:0]        vel_snap;
    logic [DATA_W-1:0]        err;
    logic [ACC_W-1:0]         integral;
    logic signed [PROD_W-1:0] p_term, i_term, ff_term;
    logic signed [PROD_W-1:0] kp_x, ki_x, err_x, int_x;
    logic signed [SUM_W-1:0]  sum, v;
    wide_t                    err_w, int_w, v_w, clamped;
    logic                     in_deadband, windup_hold;

    assign tick = (div_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    vel_estimator #(
        .DATA_W  (DATA_W),
        .VEL_WIN (VEL_WIN)
    ) u_vel_estimator (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .pos     (actual_pos),
        .vel     (actual_vel)
    );

    assign err_w = {{(WIDE_W-DATA_W){err[DATA_W-1]}}, err};
    assign int_w = {{(WIDE_W-ACC_W){integral[ACC_W-1]}}, integral};
    assign in_deadband = (err_w < wide_t'(DEADBAND)) && (err_w > -wide_t'(DEADBAND));
    // Hold only when integrating would push further into saturation.
    assign windup_hold = saturated && (err[DATA_W-1] == control_signal[OUT_W-1]);

    assign kp_x  = {{(PROD_W-GAIN_W){1'b0}}, kp};
    assign ki_x  = {{(PROD_W-GAIN_W){1'b0}}, ki};
    assign err_x = {{(PROD_W-DATA_W){err[DATA_W-1]}}, err};
    assign int_x = {{(PROD_W-ACC_W){integral[ACC_W-1]}}, integral};

    assign sum = {{2{p_term[PROD_W-1]}}, p_term} + {{2{i_term[PROD_W-1]}}, i_term}
               + {{2{ff_term[PROD_W-1]}}, ff_term};
    assign v   = sum >>> OUT_SHIFT;
    assign v_w = {{(WIDE_W-SUM_W){v[SUM_W-1]}}, v};
    assign clamped = clamp(v_w, -wide_t'(OUT_LIMIT), wide_t'(OUT_LIMIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            vel_snap       <= '0;
            err            <= '0;
            integral       <= '0;
            p_term         <= '0;
            i_term         <= '0;
            control_signal <= '0;
            saturated      <= 1'b0;
            ctrl_valid     <= 1'b0;
        end else if (!enable) begin
            state          <= ST_IDLE;
            integral       <= '0;
            control_signal <= '0;
            saturated      <= 1'b0;
            ctrl_valid     <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Capture the velocity before this tick's window update lands.
                    if (tick) begin
                        vel_snap <= actual_vel;
                        state    <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    err   <= desired_vel - vel_snap;
                    state <= ST_INT;
                end
                ST_INT: begin
                    if (!in_deadband && !windup_hold) begin
                        integral <= ACC_W'(sat_add(int_w, err_w, ACC_W));
                    end
                    state <= ST_MUL;
                end
                ST_MUL: begin
                    p_term <= kp_x * err_x;
                    i_term <= ki_x * int_x;
                    state  <= ST_OUT;
                end
                ST_OUT: begin
                    control_signal <= OUT_W'(clamped);
                    saturated      <= (clamped >= wide_t'(AW_LIMIT)) ||
                                      (clamped <= -wide_t'(AW_LIMIT));
                    ctrl_valid     <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (clear_int) integral <= '0;
        end
    end

`ifdef PI_VEL_FF_EN
    logic signed [PROD_W-1:0] kff_x, des_x;

    assign kff_x = {{(PROD_W-GAIN_W){1'b0}}, kff};
    assign des_x = {{(PROD_W-DATA_W){desired_vel[DATA_W-1]}}, desired_vel};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         ff_term <= '0;
        else if (enable && state == ST_MUL) ff_term <= kff_x * des_x;
    end
`else
    assign ff_term = '0;
`endif

endmodule

// File: tb/tb_pi_vel_ctrl_param.sv
// Directed self-checking bench for pi_vel_ctrl_param (CLK_DIV=16, VEL_WIN=4, OUT_SHIFT=8).
module tb_pi_vel_ctrl_param;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear_int;
    logic [31:0] desired_vel;
    logic [31:0] actual_pos;
    logic [15:0] kp, ki, kff;
    logic [31:0] actual_vel;
    logic [15:0] control_signal;
    logic        ctrl_valid;
    logic        saturated;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pi_vel_ctrl_param #(
        .CLK_DIV   (16),
        .VEL_WIN   (4),
        .OUT_SHIFT (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .clear_int      (clear_int),
        .desired_vel    (desired_vel),
        .actual_pos     (actual_pos),
        .kp             (kp),
        .ki             (ki),
`ifdef PI_VEL_FF_EN
        .kff            (kff),
`endif
        .actual_vel     (actual_vel),
        .control_signal (control_signal),
        .ctrl_valid     (ctrl_valid),
        .saturated      (saturated)
    );

    // Leaves the bench #1 after a posedge with the tick divider at 0.
    task automatic do_reset();
        enable = 0; clear_int = 0; desired_vel = 0; actual_pos = 0;
        kp = 0; ki = 0; kff = 0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    // Called #1 after a tick edge; checks this sequence's result, then realigns.
    task automatic pi_step(input logic [31:0] des, input logic [15:0] gp, input logic [15:0] gi,
                           input logic [15:0] exp_cs, input logic exp_sat, input string name);
        desired_vel = des; kp = gp; ki = gi;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (ctrl_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ctrl_valid: got %b want 1", name, ctrl_valid);
        end
        n_vec++;
        if (control_signal !== exp_cs) begin
            n_bad++;
            $display("FAIL %s control_signal: got %0d want %0d", name,
                     $signed(control_signal), $signed(exp_cs));
        end
        n_vec++;
        if (saturated !== exp_sat) begin
            n_bad++;
            $display("FAIL %s saturated: got %b want %b", name, saturated, exp_sat);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first_edge;
        int pulses;
        do_reset();
        n_vec++;
        if ({actual_vel, control_signal, ctrl_valid, saturated} !== 50'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got vel=%0d cs=%0d v=%b s=%b want all 0",
                     actual_vel, control_signal, ctrl_valid, saturated);
        end
        enable = 1; kp = 16'd256; ki = 0; desired_vel = 32'd100;
        repeat (16) @(posedge clk);
        #1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (ctrl_valid !== 1'(e == 4)) begin
                n_bad++;
                $display("FAIL latency edge %0d ctrl_valid: got %b want %b", e, ctrl_valid, e == 4);
            end
        end
        n_vec++;
        if (control_signal !== 16'd100) begin
            n_bad++;
            $display("FAIL first_result control_signal: got %0d want 100", $signed(control_signal));
        end
        repeat (11) @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1 reset_n = 0;
        #1;
        n_vec++;
        if ({control_signal, ctrl_valid, saturated} !== 18'd0) begin
            n_bad++;
            $display("FAIL midseq_reset: got cs=%0d v=%b s=%b want 0 0 0",
                     $signed(control_signal), ctrl_valid, saturated);
        end
        @(posedge clk);
        #1 reset_n = 1;
        first_edge = 0;
        pulses = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if (ctrl_valid === 1'b1) begin
                pulses++;
                if (first_edge == 0) first_edge = e;
            end
        end
        n_vec++;
        if (first_edge != 20) begin
            n_bad++;
            $display("FAIL first_valid_edge: got %0d want 20", first_edge);
        end
        n_vec++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL valid_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_velocity();
        logic [31:0] exp_vel;
        do_reset();
        for (int j = 1; j <= 12; j++) begin
            actual_pos = 32'(5 * j);
            repeat (16) @(posedge clk);
            #1;
            exp_vel = (j >= 4) ? 32'd20 : 32'd0;
            n_vec++;
            if (actual_vel !== exp_vel) begin
                n_bad++;
                $display("FAIL velocity tick %0d: got %0d want %0d", j, actual_vel, exp_vel);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_vel;
        do_reset();
        for (int j = 1; j <= 12; j++) begin
            actual_pos = 32'h7FFF_FFF0 + 32'(8 * (j - 4));
            repeat (16) @(posedge clk);
            #1;
            exp_vel = (j < 4) ? 32'd0 : (j < 8) ? 32'h7FFF_FFF0 : 32'd32;
            n_vec++;
            if (actual_vel !== exp_vel) begin
                n_bad++;
                $display("FAIL wrap tick %0d: got %h want %h", j, actual_vel, exp_vel);
            end
        end
    endtask

    task automatic test_proportional();
        do_reset();
        enable = 1; kp = 16'd256; desired_vel = 32'd100;
        repeat (16) @(posedge clk);
        #1;
        pi_step(32'd100, 16'd256, 16'd0, 16'd100, 1'b0, "prop_100");
        pi_step(-32'sd100, 16'd256, 16'd0, -16'sd100, 1'b0, "prop_m100");
        pi_step(32'd7, 16'd512, 16'd0, 16'd14, 1'b0, "prop_x2");
    endtask

    task automatic test_antiwindup();
        do_reset();
        enable = 1; kp = 16'd256; ki = 16'd1; desired_vel = 32'd10000;
        repeat (16) @(posedge clk);
        #1;
        pi_step(32'd10000, 16'd256, 16'd1, 16'd4000, 1'b1, "sat_1");
        pi_step(32'd10000, 16'd256, 16'd1, 16'd4000, 1'b1, "sat_2");
        pi_step(32'd10000, 16'd256, 16'd1, 16'd4000, 1'b1, "sat_3");
        pi_step(-32'sd10000, 16'd256, 16'd1, -16'sd4000, 1'b1, "sat_reverse");
        // Output now equals the integral: zero only if the saturated ticks held it.
        pi_step(32'd0, 16'd0, 16'd256, 16'd0, 1'b0, "windup_probe");
    endtask

    task automatic test_deadband_clear_enable();
        int pulses;
        do_reset();
        enable = 1; ki = 16'd256; desired_vel = 32'd5;
        repeat (16) @(posedge clk);
        #1;
        pi_step(32'd5, 16'd0, 16'd256, 16'd5, 1'b0, "int_5");
        pi_step(32'd2, 16'd0, 16'd256, 16'd5, 1'b0, "deadband_p2");
        pi_step(-32'sd2, 16'd0, 16'd256, 16'd5, 1'b0, "deadband_m2");
        pi_step(32'd3, 16'd0, 16'd256, 16'd8, 1'b0, "deadband_edge");
        pi_step(-32'sd3, 16'd0, 16'd256, 16'd5, 1'b0, "int_back");
        desired_vel = 0;
        clear_int = 1;
        @(posedge clk);
        #1 clear_int = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (ctrl_valid !== 1'b1 || control_signal !== 16'd0) begin
            n_bad++;
            $display("FAIL clear_int: got v=%b cs=%0d want 1 0", ctrl_valid, $signed(control_signal));
        end
        repeat (12) @(posedge clk);
        #1;
        pi_step(32'd10000, 16'd256, 16'd256, 16'd4000, 1'b1, "pre_disable");
        enable = 0;
        @(posedge clk);
        #1;
        n_vec++;
        if (control_signal !== 16'd0 || saturated !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_outputs: got cs=%0d s=%b want 0 0",
                     $signed(control_signal), saturated);
        end
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (ctrl_valid === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL disable_valid: got %0d pulses want 0", pulses);
        end
        enable = 1; kp = 0; ki = 16'd256; desired_vel = 0;
        repeat (11) @(posedge clk);
        #1;
        pi_step(32'd0, 16'd0, 16'd256, 16'd0, 1'b0, "reenable_zero_int");
    endtask

`ifdef PI_VEL_FF_EN
    task automatic test_feedforward();
        do_reset();
        enable = 1; kff = 16'd256; desired_vel = 32'd50;
        repeat (16) @(posedge clk);
        #1;
        pi_step(32'd50, 16'd0, 16'd0, 16'd50, 1'b0, "feedforward");
    endtask
`endif

    initial begin
        test_reset();
        test_velocity();
        test_wrap();
        test_proportional();
        test_antiwindup();
        test_deadband_clear_enable();
`ifdef PI_VEL_FF_EN
        test_feedforward();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pi_vel_ctrl_param.md
# pi_vel_ctrl_param

Parametrised PI velocity controller for the DC motor control path. It derives velocity from an encoder position count and runs a PI loop with conditional anti-windup and full-width output saturation. It drives a signed PWM duty command into the PWM generator. All logic runs on the system clock: a divide counter produces a single-cycle tick, and each tick launches a short multi-cycle compute sequence. There is no derived clock.

## Interface
Parameters:
- DATA_W, 32, width of position, velocity and error
- GAIN_W, 16, width of unsigned gains
- ACC_W, 48, width of the integral accumulator
- OUT_W, 16, width of the control output
- CLK_DIV, 5000, clk cycles per control tick (100 MHz -> 20 kHz); must be ≥ 8
- VEL_WIN, 10, ticks per velocity window; must be ≥ 1
- OUT_SHIFT, 32, arithmetic right shift applied to the PI sum
- OUT_LIMIT, 4000, symmetric output clamp; must be < 2^(OUT_W-1)
- AW_LIMIT, 3900, anti-windup threshold on |control_signal|
- DEADBAND, 3, integration is held while |error| < DEADBAND

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  loop enable; low forces the output to zero
- clear_int  in  1  synchronous integral clear
- desired_vel  in  DATA_W  signed target velocity, in counts per window
- actual_pos  in  DATA_W  signed encoder count, free-running with wrap
- kp  in  GAIN_W  unsigned proportional gain
- ki  in  GAIN_W  unsigned integral gain
- actual_vel  out  DATA_W  signed measured velocity
- control_signal  out  OUT_W  signed clamped command
- ctrl_valid  out  1  one-cycle pulse when control_signal updates
- saturated  out  1  the last update was clamped

## Operation
- Tick generator: the counter runs 0..CLK_DIV-1. tick is high for the one cycle where count == CLK_DIV-1, then the counter wraps to 0.
- Velocity estimator, on each tick:
  - Sample actual_pos and increment the window counter.
  - When the window counter reaches VEL_WIN-1, set actual_vel <= sample - win_start and win_start <= sample.
  - The subtraction is modulo 2^DATA_W, so encoder wrap is absorbed.
  - The estimator runs regardless of enable.
- FSM states are IDLE, ERR, INT, MUL and OUT. Each non-IDLE state lasts one clk cycle.
  - IDLE -> ERR on tick when enable = 1.
  - ERR: err <= desired_vel - actual_vel, wrapping at DATA_W. actual_vel is the value held before this tick's estimator update.
  - INT, in priority order:
    - clear_int: integral <= 0.
    - Otherwise, if |err| < DEADBAND: hold.
    - Otherwise, if saturated = 1 and sign(err) == sign(control_signal): hold (conditional anti-windup; integration that reduces the output is still allowed).
    - Otherwise: integral <= sat_ACC_W(integral + err), clamped to the ACC_W signed range with no wrap.
  - MUL: p <= {0,kp} * err and i <= {0,ki} * integral. These are signed products at full width, with PROD_W = ACC_W+GAIN_W+1.
  - OUT:
    - sum = p + i (+ ff), computed in PROD_W+2 bits.
    - v = sum >>> OUT_SHIFT.
    - The clamp is applied to the full-width v, never to a truncated value.
    - If v > OUT_LIMIT, control_signal <= OUT_LIMIT; if v < -OUT_LIMIT, control_signal <= -OUT_LIMIT; otherwise control_signal <= v.
    - saturated <= (|control_signal| ≥ AW_LIMIT).
    - ctrl_valid <= 1, then return to IDLE.
- enable low: the FSM is forced to IDLE; control_signal, integral and saturated are set to 0; ctrl_valid stays 0. On the first tick after enable rises, the sequence starts from a zero integral.
- clear_int high outside INT: the integral is zeroed on that cycle; clear_int has priority over an INT update.
- A tick while the FSM is busy cannot occur, given the CLK_DIV ≥ 8 constraint.

## Timing
- Reset value of every output and register is 0: actual_vel, control_signal, ctrl_valid, saturated, integral, counters and FSM = IDLE.
- A tick at cycle T gives: ERR at T+1, INT at T+2, MUL at T+3, OUT at T+4.
- control_signal and saturated are registered at the end of T+4 and visible from T+5. ctrl_valid is high during T+5 only.
- An actual_vel update is visible from T+1 of the tick that closes a window.
- A reset asserted mid-sequence aborts the sequence immediately; no ctrl_valid is issued.

## Configuration
- PI_VEL_FF_EN defined:
  - Adds input port kff [GAIN_W-1:0], an unsigned feedforward gain.
  - MUL additionally computes ff <= {0,kff} * desired_vel.
  - ff is added to the OUT sum before the shift and clamp.
- PI_VEL_FF_EN undefined: the kff port is absent and ff = 0. Behaviour is otherwise identical.

## Structure
- Package pi_vel_pkg holds:
  - the FSM state enum;
  - the PROD_W derivation;
  - a saturating add function;
  - a clamp function.
- Sub-module vel_estimator holds the tick-qualified position sampler and window differencer (parameters DATA_W and VEL_WIN).

## Test plan
Bench parameters: CLK_DIV=16, VEL_WIN=4, OUT_SHIFT=8, with remaining parameters at their defaults.
- Reset: assert reset_n low mid-sequence, then release -> all outputs 0; the first ctrl_valid appears exactly 5 cycles after the first tick with enable=1.
- Velocity: actual_pos increments by 5 per tick -> actual_vel = 20 after each 4-tick window.
- Wrap: actual_pos steps by +8 per tick starting at 0x7FFFFFF0 -> actual_vel = 32 across the signed wrap.
- Proportional: kp=256, ki=0, desired_vel=100, actual_vel=0 -> control_signal = 100 and saturated = 0.
- Saturation and anti-windup: kp=256, ki=1, desired_vel=10000 -> control_signal = 4000 and saturated = 1; the integral stops growing; setting desired_vel=-10000 resumes integration toward 0.
- Deadband, clear and enable:
  - err = 2 -> integral unchanged.
  - clear_int pulse -> integral = 0.
  - enable low -> control_signal = 0 and no ctrl_valid.
  - With PI_VEL_FF_EN: kff=256, kp=ki=0, desired_vel=50 -> control_signal = 50.
